axis_tlp_fifo: RTL



---
 rtl/axis_tlp_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/axis_tlp_fifo.sv
// First-word-fall-through AXI4-Stream buffer for 64-bit PCIe TLP beats feeding the AXI-to-OCP bridge.
// Also flags mid-packet starvation (axis_underflow) and rejected pushes while full (axis_overflow).
module axis_tlp_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [63:0]   s_axis_tdata,
    input  logic [7:0]    s_axis_tkeep,
    input  logic          s_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tkeep,
    output logic          m_axis_tlast,
    output logic          axis_underflow,
    output logic          axis_overflow,
    output logic [AW:0]   fifo_level
);

    localparam int unsigned DW = 73;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          in_pkt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on occupancy, so a full FIFO never passes a beat through.
    assign s_axis_tready = ~reset & ~full;
    assign m_axis_tvalid = ~empty;

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    assign head = mem[rd_ptr];
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head;
    assign fifo_level = count;

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            in_pkt         <= 1'b0;
            axis_underflow <= 1'b0;
            axis_overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                in_pkt <= ~m_axis_tlast;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Starvation only matters while the bridge is partway through a TLP.
            axis_underflow <= m_axis_tready & empty & in_pkt;
            axis_overflow  <= s_axis_tvalid & full;
        end
    end

endmodule
